// File: rtl/jrrencoder_pkg.sv
// Shared constants for the encoder/decoder family: default code width and the
// matching request-line count, plus a helper used to build the binary encode masks.
package jrrencoder_pkg;

  localparam int JRR_N  = 2;
  localparam int JRR_N2 = 2 ** JRR_N;

  // Bit j of the result is bit b of the integer j: the set of indices whose
  // binary code has bit b set.
  function automatic logic [31:0] code_bit_mask(input int b);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 32; j++) m[j] = ((j >> b) & 1) != 0;
    return m;
  endfunction

endpackage

// File: rtl/jrrencoder_if.sv
// Request/grant bus between the requesting units, the consumer and the encoder.
interface jrrencoder_if
  import jrrencoder_pkg::*;
#(
  parameter int N  = JRR_N,
  parameter int N2 = JRR_N2
);
  logic [N2-1:0] bis;
  logic          wdone;
  logic [N-1:0]  bos;
  logic [N2-1:0] bgnt;
  logic          wvalid;

  modport master (output bis, wdone, input bos, bgnt, wvalid);
  modport slave  (input bis, wdone, output bos, bgnt, wvalid);
endinterface

// File: rtl/jrrencoder_jprienc.sv
// Rotating priority encoder: first set request at or above ptr, else the lowest
// set request overall. With ptr tied to 0 it is a plain priority encoder.
module jprienc
  import jrrencoder_pkg::*;
#(
  parameter int N  = JRR_N,
  parameter int N2 = JRR_N2
) (
  input  logic [N2-1:0] bis,
  input  logic [N-1:0]  ptr,
  output logic          found,
  output logic [N-1:0]  idx
);
  logic [N2-1:0] pdec, ge, req_hi;
  logic [N2-1:0] pr_hi, pr_all, below_hi, below_all, nb_hi, nb_all;
  logic [N2-1:0] g_hi, g_all, g_lo_keep, g;
  logic          n_any_hi;

  // ge is a thermometer of indices >= ptr; requests there win over the wrap-around.
  jdecoder   #(N, N2) u_pdec (.a(ptr), .en(1'b1), .y(pdec));
  jprefix_or #(N2)    u_ge   (.x(pdec), .p(ge));
  jand       #(N2)    u_hi   (.a(bis), .b(ge), .y(req_hi));

  jprefix_or #(N2) u_pr_hi  (.x(req_hi), .p(pr_hi));
  jprefix_or #(N2) u_pr_all (.x(bis),    .p(pr_all));
  assign below_hi  = {pr_hi[N2-2:0],  1'b0};
  assign below_all = {pr_all[N2-2:0], 1'b0};

  jnot #(N2) u_nb_hi  (.a(below_hi),  .y(nb_hi));
  jnot #(N2) u_nb_all (.a(below_all), .y(nb_all));
  jand #(N2) u_g_hi   (.a(req_hi), .b(nb_hi),  .y(g_hi));
  jand #(N2) u_g_all  (.a(bis),    .b(nb_all), .y(g_all));

  jnot #(1)  u_nany (.a(pr_hi[N2-1]), .y(n_any_hi));
  jand #(N2) u_keep (.a(g_all), .b({N2{n_any_hi}}), .y(g_lo_keep));
  jor  #(N2) u_sel  (.a(g_hi), .b(g_lo_keep), .y(g));

  assign found = pr_all[N2-1];

  for (genvar b = 0; b < N; b++) begin : g_enc
    localparam logic [N2-1:0] MASK = N2'(code_bit_mask(b));
    logic [N2-1:0] gm;
    jand       #(N2) u_m (.a(g), .b(MASK), .y(gm));
    jreduce_or #(N2) u_r (.x(gm), .y(idx[b]));
  end
endmodule

// File: rtl/jrrencoder_prim.sv
// Gate primitives and the N-to-2^N decoder shared by the encoder datapath.
module jand #(parameter int W = 1) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a & b;
endmodule

module jor #(parameter int W = 1) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a | b;
endmodule

module jnot #(parameter int W = 1) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = ~a;
endmodule

// p[j] = x[0] | ... | x[j]
module jprefix_or #(parameter int W = 2) (
  input  logic [W-1:0] x,
  output logic [W-1:0] p
);
  assign p[0] = x[0];
  for (genvar j = 1; j < W; j++) begin : g_chain
    jor #(1) u_or (.a(p[j-1]), .b(x[j]), .y(p[j]));
  end
endmodule

module jreduce_or #(parameter int W = 2) (
  input  logic [W-1:0] x,
  output logic         y
);
  logic [W-1:0] c;
  assign c[0] = x[0];
  for (genvar j = 1; j < W; j++) begin : g_chain
    jor #(1) u_or (.a(c[j-1]), .b(x[j]), .y(c[j]));
  end
  assign y = c[W-1];
endmodule

module jdecoder
  import jrrencoder_pkg::*;
#(
  parameter int N  = JRR_N,
  parameter int N2 = JRR_N2
) (
  input  logic [N-1:0]  a,
  input  logic          en,
  output logic [N2-1:0] y
);
  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end
endmodule

// File: rtl/jrrencoder.sv
// Registered round-robin encoder: grants one of N2 requesters by rotating
// priority and holds code/grant until completion or withdrawal.
module jrrencoder
  import jrrencoder_pkg::*;
#(
  parameter int N  = JRR_N,
  parameter int N2 = JRR_N2
) (
  input  logic        wclk,
  input  logic        wreset,
  jrrencoder_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  ptr, ptr_nxt, code, code_nxt;
  logic          found, wvalid;
  logic [N-1:0]  idx;
  logic [N2-1:0] bgnt;

  jprienc #(N, N2) u_pri (.bis(bus.bis), .ptr(ptr), .found(found), .idx(idx));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk) begin
    if (wreset) begin
      state <= IDLE;
      ptr   <= '0;
      code  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      code  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    code_nxt  = code;
    case (state)
      IDLE: if (found) begin
        code_nxt  = idx;
        state_nxt = GRANT;
      end
      GRANT: if (bus.wdone || !bus.bis[code]) begin
        // N-bit add wraps N2-1 back to 0.
        ptr_nxt   = code + N'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wvalid = (state == GRANT);

  jdecoder #(N, N2) u_gdec (.a(code), .en(wvalid), .y(bgnt));

  assign bus.wvalid = wvalid;
  assign bus.bos    = wvalid ? code : '0;
  assign bus.bgnt   = bgnt;
endmodule

// File: tb/tb_jrrencoder.sv
// Scoreboard bench for jrrencoder: a queue-based reference model predicts every
// cycle's outputs and the sequence of granted codes.
module tb_jrrencoder;
  localparam int N  = 2;
  localparam int N2 = 4;

  typedef struct {
    logic          wv;
    logic [N-1:0]  bos;
    logic [N2-1:0] bgnt;
  } exp_t;

  logic wclk;
  logic wreset;
  jrrencoder_if #(.N(N), .N2(N2)) bus ();

  jrrencoder #(.N(N), .N2(N2)) dut (.wclk(wclk), .wreset(wreset), .bus(bus.slave));

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  exp_t exp_q[$];
  int   grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_grant  = -1;  // granted requester index, -1 when idle
  int   m_ptr    = 0;
  logic prev_wv  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge with the inputs currently driven.
  task automatic model_edge(input logic rst, input logic [N2-1:0] b, input logic wd);
    exp_t e;
    if (rst) begin
      m_grant = -1;
      m_ptr   = 0;
    end else if (m_grant < 0) begin
      for (int k = 0; k < N2; k++) begin
        int j;
        j = (m_ptr + k) % N2;
        if (b[j]) begin
          m_grant = j;
          grant_q.push_back(j);
          break;
        end
      end
    end else if (wd || !b[m_grant]) begin
      m_ptr   = (m_grant + 1) % N2;
      m_grant = -1;
    end
    e.wv   = (m_grant >= 0);
    e.bos  = (m_grant >= 0) ? N'(m_grant) : '0;
    e.bgnt = (m_grant >= 0) ? N2'(1 << m_grant) : '0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [N2-1:0] b, input logic wd);
    wreset  = rst;
    bus.bis = b;
    bus.wdone = wd;
    @(posedge wclk);
    model_edge(rst, b, wd);
    #1;
  endtask

  task automatic run(input logic rst, input logic [N2-1:0] b, input logic wd, input int cycles);
    for (int i = 0; i < cycles; i++) step(rst, b, wd);
  endtask

  // wdone asserted on the first cycle of every grant.
  task automatic run_auto(input logic [N2-1:0] b, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, b, m_grant >= 0);
  endtask

  // Monitor: compares every cycle's outputs and each newly granted code.
  always @(negedge wclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("wvalid", 32'(bus.wvalid), 32'(e.wv));
      check("bos",    32'(bus.bos),    32'(e.bos));
      check("bgnt",   32'(bus.bgnt),   32'(e.bgnt));
      if (bus.wvalid === 1'b1 && prev_wv !== 1'b1) begin
        if (grant_q.size() == 0) check("grant_seq_pending", 32'(grant_q.size()), 32'd1);
        else check("grant_seq_code", 32'(bus.bos), 32'(grant_q.pop_front()));
      end
      prev_wv = bus.wvalid;
    end
  end

  initial begin
    wreset    = 1'b1;
    bus.bis   = '0;
    bus.wdone = 1'b0;

    // Reset with all requests up, then round robin 0,1,2,3,0,1.
    run(1'b1, 4'b1111, 1'b0, 2);
    run_auto(4'b1111, 12);

    // Single hold, unaffected by other request bits.
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b0, 4'b0100, 1'b0, 3);
    run(1'b0, 4'b0111, 1'b0, 4);
    run(1'b0, 4'b0111, 1'b1, 1);

    // Pointer skip and wrap: code 1, then 0001 -> 0, then 1010 -> 1.
    run(1'b1, 4'b0000, 1'b0, 1);
    run_auto(4'b0010, 2);
    run_auto(4'b0001, 2);
    run_auto(4'b1010, 2);

    // Withdrawal of code 3, without and with a simultaneous wdone.
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b0, 4'b1000, 1'b0, 2);
    run(1'b0, 4'b0011, 1'b0, 3);
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b0, 4'b1000, 1'b0, 2);
    run(1'b0, 4'b0011, 1'b1, 1);
    run(1'b0, 4'b0011, 1'b0, 2);

    // Reset mid-grant of code 2, then re-grant of code 2.
    run(1'b1, 4'b0000, 1'b0, 1);
    run(1'b0, 4'b0100, 1'b0, 2);
    run(1'b1, 4'b0100, 1'b0, 1);
    run(1'b0, 4'b0100, 1'b0, 2);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      logic [N2-1:0] b;
      b = N2'($urandom);
      if ($urandom_range(0, 3) == 0) b = '0;
      step($urandom_range(0, 59) == 0, b, $urandom_range(0, 3) == 0);
    end

    run(1'b0, 4'b0000, 1'b1, 2);
    @(negedge wclk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("grants_drained", 32'(grant_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
